// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and one-hot operand-select codes
// for the alu_seq_ctrl operation sequencer.
package alu_seq_pkg;

  localparam int W         = 8;
  localparam int MUL_STEPS = 8;
  localparam int CNT_W     = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ALU  = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

  localparam logic [3:0] SEL_B    = 4'b0001;
  localparam logic [3:0] SEL_NB   = 4'b0010;
  localparam logic [3:0] SEL_A    = 4'b0100;
  localparam logic [3:0] SEL_ZERO = 4'b1000;

endpackage

// File: rtl/Add_rca_8.sv
// 8-bit ripple-carry adder built from a chain of full adders.
module Add_rca_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[8];

endmodule

// File: rtl/Mux4.sv
// Four-input AND-OR multiplexer driven by a one-hot select.
module Mux4 #(
  parameter int k = 8
) (
  input  logic [k-1:0] in0,
  input  logic [k-1:0] in1,
  input  logic [k-1:0] in2,
  input  logic [k-1:0] in3,
  input  logic [3:0]   sel,
  output logic [k-1:0] out
);

  always_comb begin
    out = ({k{sel[0]}} & in0) |
          ({k{sel[1]}} & in1) |
          ({k{sel[2]}} & in2) |
          ({k{sel[3]}} & in3);
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer sharing one ripple-carry adder between ADD, SUB and an
// 8-step shift-add multiply, with a start/busy handshake and done pulse.
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           c_out
);

  state_e               state_q, state_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic [2*W-1:0]       p_q, p_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]       result_q, result_d;
  logic                 c_out_q, c_out_d;
  logic                 done_q, done_d;

  logic [W-1:0]         add_a;
  logic [W-1:0]         add_b;
  logic                 add_cin;
  logic [W-1:0]         add_sum;
  logic                 add_cout;
  logic [3:0]           sel;
  logic [2*W-1:0]       p_shift;

  // Operand B comes through the one-hot mux; operand A is either the
  // latched A (ADD/SUB) or the running high half of the product (MUL).
  always_comb begin
    sel     = SEL_ZERO;
    add_a   = a_q;
    add_cin = 1'b0;
    case (state_q)
      ST_ALU: begin
        if (op_q == OP_ADD) begin
          sel = SEL_B;
        end else if (op_q == OP_SUB) begin
          sel     = SEL_NB;
          add_cin = 1'b1;
        end
      end
      ST_MUL: begin
        add_a = p_q[2*W-1:W];
        sel   = p_q[0] ? SEL_A : SEL_ZERO;
      end
      default: ;
    endcase
  end

  Mux4 #(.k(W)) u_mux (
    .in0 (b_q),
    .in1 (~b_q),
    .in2 (a_q),
    .in3 ({W{1'b0}}),
    .sel (sel),
    .out (add_b)
  );

  Add_rca_8 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The 17-bit {carry, hi, lo} shifted right by one always leaves a zero
  // in the carry position, so only the 16 product bits are stored.
  assign p_shift = {add_cout, add_sum, p_q[W-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          p_d     = {{W{1'b0}}, b};
          cnt_d   = '0;
          state_d = (op == OP_MUL) ? ST_MUL : ST_ALU;
        end
      end
      ST_ALU: begin
        if (op_q == OP_RSV) begin
          result_d = '0;
          c_out_d  = 1'b0;
        end else begin
          result_d = {{W{1'b0}}, add_sum};
          c_out_d  = add_cout;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_MUL: begin
        p_d   = p_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
          result_d = p_shift;
          c_out_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl with hand-computed expected values.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        c_out;

  int vectorCount = 0;
  int missCount   = 0;

  alu_seq_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Waits up to a bounded number of edges for done and returns the latency.
  task automatic waitDone(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      stepClock();
      lat++;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] opIn,
                               input logic [7:0] aIn, input logic [7:0] bIn,
                               input int expLat, input logic [15:0] expRes,
                               input logic expC);
    int lat;
    start = 1'b1;
    op    = opIn;
    a     = aIn;
    b     = bIn;
    stepClock();
    start = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    waitDone(lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_res"}, 32'(result), 32'(expRes));
    checkOutput({tag, "_cout"}, 32'(c_out), 32'(expC));
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int doneSeen;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 8'h00;
    b     = 8'h00;
    stepClock();
    stepClock();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_res", 32'(result), 32'd0);
    checkOutput("rst_cout", 32'(c_out), 32'd0);
    rst = 1'b0;
    stepClock();

    applyStimulus("add200_100", 2'b00, 8'd200, 8'd100, 1, 16'h002C, 1'b1);
    applyStimulus("sub5_7",     2'b01, 8'd5,   8'd7,   1, 16'h00FE, 1'b0);
    applyStimulus("sub7_5",     2'b01, 8'd7,   8'd5,   1, 16'h0002, 1'b1);
    applyStimulus("rsv9_9",     2'b11, 8'd9,   8'd9,   1, 16'h0000, 1'b0);
    applyStimulus("mul13_11",   2'b10, 8'd13,  8'd11,  8, 16'h008F, 1'b0);
    applyStimulus("mul255_255", 2'b10, 8'd255, 8'd255, 8, 16'hFE01, 1'b0);
    applyStimulus("mul0_200",   2'b10, 8'd0,   8'd200, 8, 16'h0000, 1'b0);

    // Start held high with changing inputs during a multiply, then a
    // back-to-back ADD accepted in the done cycle.
    start = 1'b1;
    op    = 2'b10;
    a     = 8'd3;
    b     = 8'd4;
    stepClock();
    op = 2'b00;
    a  = 8'd99;
    b  = 8'd77;
    waitDone(lat);
    checkOutput("mulhold_lat", 32'(lat), 32'd8);
    checkOutput("mulhold_res", 32'(result), 32'h000C);
    a = 8'd1;
    b = 8'd1;
    stepClock();
    start = 1'b0;
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    checkOutput("b2b_done", 32'(done), 32'd0);
    stepClock();
    checkOutput("b2b_donepulse", 32'(done), 32'd1);
    checkOutput("b2b_res", 32'(result), 32'h0002);
    stepClock();
    checkOutput("b2b_doneone", 32'(done), 32'd0);

    // Reset asserted at the fourth multiply edge aborts the operation.
    start = 1'b1;
    op    = 2'b10;
    a     = 8'd13;
    b     = 8'd11;
    stepClock();
    start = 1'b0;
    stepClock();
    stepClock();
    stepClock();
    rst = 1'b1;
    stepClock();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_res", 32'(result), 32'd0);
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      stepClock();
      if (done) doneSeen++;
    end
    checkOutput("abort_nodone", 32'(doneSeen), 32'd0);
    applyStimulus("add2_3", 2'b00, 8'd2, 8'd3, 1, 16'h0005, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
